// File: rtl/fsrc_tx_rate_ctrl.sv
// Multi-channel TX fractional rate controller: inserts fill beats into an AXI-Stream flow when a
// phase accumulator carries. Define FSRC_TX_DEBUG_EN to build the insert/underflow counters.
module fsrc_tx_rate_ctrl #(
    parameter int unsigned NUM_OF_CHANNELS     = 4,
    parameter int unsigned SAMPLES_PER_CHANNEL = 2,
    parameter int unsigned SAMPLE_DATA_WIDTH   = 16,
    parameter int unsigned ACCUM_WIDTH         = 32,
    parameter logic [SAMPLE_DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                                                           clk,
    input  logic                                                           reset,
    input  logic                                                           enable,
    input  logic                                                           start,
    input  logic                                                           stop,
    input  logic                                                           accum_set,
    input  logic [ACCUM_WIDTH-1:0]                                         accum_set_val,
    input  logic [ACCUM_WIDTH-1:0]                                         accum_add_val,
    input  logic [NUM_OF_CHANNELS-1:0]                                     fill_mask,
    input  logic                                                           s_axis_valid,
    output logic                                                           s_axis_ready,
    input  logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] s_axis_data,
    output logic                                                           m_axis_valid,
    input  logic                                                           m_axis_ready,
    output logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] m_axis_data,
    output logic                                                           running,
    output logic                                                           underflow,
    output logic [31:0]                                                    insert_count,
    output logic [31:0]                                                    underflow_count
);

    localparam int unsigned CH_WIDTH   = SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH;
    localparam int unsigned DATA_WIDTH = NUM_OF_CHANNELS * CH_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StBypass,
        StRun,
        StDrain
    } state_e;

    state_e                  state;
    logic [ACCUM_WIDTH-1:0]  acc;
    logic [ACCUM_WIDTH-1:0]  acc_sum;
    logic                    acc_carry;
    logic [DATA_WIDTH-1:0]   last_beat;
    logic [DATA_WIDTH-1:0]   fill_beat;

    logic slot_free;
    logic ins;
    logic in_fire;
    logic run_start;
    logic ins_beat;
    logic run_accept;
    logic starve;

    assign slot_free = !m_axis_valid || m_axis_ready;
    assign {acc_carry, acc_sum} = {1'b0, acc} + {1'b0, accum_add_val};
    assign ins = acc_carry && (state == StRun);

    always_comb begin
        s_axis_ready = 1'b0;
        case (state)
            StBypass, StDrain: s_axis_ready = slot_free;
            StRun:             s_axis_ready = slot_free && !ins;
            default:           s_axis_ready = 1'b0;
        endcase
    end

    assign in_fire    = s_axis_valid && s_axis_ready;
    assign run_start  = enable && (state == StBypass) && start && !stop;
    assign ins_beat   = enable && slot_free && ins;
    assign run_accept = enable && (state == StRun) && slot_free && !ins && s_axis_valid;
    assign starve     = enable && (state == StRun) && slot_free && !ins && !s_axis_valid;
    assign running    = (state == StRun) || (state == StDrain);

    // Fill-mode channels take FILL_VALUE in every sample; the rest repeat the last accepted beat.
    always_comb begin
        fill_beat = last_beat;
        for (int unsigned c = 0; c < NUM_OF_CHANNELS; c++) begin
            if (fill_mask[c]) begin
                for (int unsigned s = 0; s < SAMPLES_PER_CHANNEL; s++) begin
                    fill_beat[c*CH_WIDTH + s*SAMPLE_DATA_WIDTH +: SAMPLE_DATA_WIDTH] = FILL_VALUE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            acc          <= '0;
            last_beat    <= '0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            underflow    <= 1'b0;
        end else if (!enable) begin
            state        <= StIdle;
            m_axis_valid <= 1'b0;
        end else begin
            // Retire an accepted beat; a new load below takes precedence.
            if (m_axis_valid && m_axis_ready) begin
                m_axis_valid <= 1'b0;
            end
            if (in_fire) begin
                m_axis_valid <= 1'b1;
                m_axis_data  <= s_axis_data;
                last_beat    <= s_axis_data;
            end

            case (state)
                StIdle: begin
                    state <= StBypass;
                    if (accum_set) begin
                        acc <= accum_set_val;
                    end
                end
                StBypass: begin
                    if (run_start) begin
                        state     <= StRun;
                        underflow <= 1'b0;
                        acc       <= accum_set ? accum_set_val : '0;
                    end else if (accum_set) begin
                        acc <= accum_set_val;
                    end
                end
                StRun: begin
                    if (ins_beat) begin
                        m_axis_valid <= 1'b1;
                        m_axis_data  <= fill_beat;
                        acc          <= acc_sum;
                    end else if (run_accept) begin
                        acc <= acc_sum;
                    end else if (starve) begin
                        underflow <= 1'b1;
                    end
                    if (stop) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (slot_free) begin
                        state <= StBypass;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef FSRC_TX_DEBUG_EN
    logic [31:0] insert_cnt;
    logic [31:0] underflow_cnt;

    always_ff @(posedge clk) begin
        if (reset || run_start) begin
            insert_cnt    <= '0;
            underflow_cnt <= '0;
        end else begin
            if (ins_beat && (insert_cnt != '1)) begin
                insert_cnt <= insert_cnt + 32'd1;
            end
            if (starve && (underflow_cnt != '1)) begin
                underflow_cnt <= underflow_cnt + 32'd1;
            end
        end
    end

    assign insert_count    = insert_cnt;
    assign underflow_count = underflow_cnt;
`else
    assign insert_count    = '0;
    assign underflow_count = '0;
`endif

endmodule

// File: tb/tb_fsrc_tx_rate_ctrl.sv
// Scoreboard bench for fsrc_tx_rate_ctrl: expected beats come from a phase model that decides
// insertion per output beat index; a monitor pops and compares every output handshake.
module tb_fsrc_tx_rate_ctrl;

    localparam int NCH = 4;
    localparam int SPC = 2;
    localparam int SW  = 16;
    localparam int AW  = 8;
    localparam int DW  = NCH * SPC * SW;
    localparam logic [SW-1:0] FILL = 16'h7FFF;

`ifdef FSRC_TX_DEBUG_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    typedef logic [DW-1:0] beat_t;

    logic           clk = 1'b0;
    logic           reset, enable, start, stop, accum_set;
    logic [AW-1:0]  accum_set_val, accum_add_val;
    logic [NCH-1:0] fill_mask;
    logic           s_axis_valid, s_axis_ready;
    beat_t          s_axis_data, m_axis_data;
    logic           m_axis_valid, m_axis_ready;
    logic           running, underflow;
    logic [31:0]    insert_count, underflow_count;

    fsrc_tx_rate_ctrl #(
        .NUM_OF_CHANNELS    (NCH),
        .SAMPLES_PER_CHANNEL(SPC),
        .SAMPLE_DATA_WIDTH  (SW),
        .ACCUM_WIDTH        (AW),
        .FILL_VALUE         (FILL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .start          (start),
        .stop           (stop),
        .accum_set      (accum_set),
        .accum_set_val  (accum_set_val),
        .accum_add_val  (accum_add_val),
        .fill_mask      (fill_mask),
        .s_axis_valid   (s_axis_valid),
        .s_axis_ready   (s_axis_ready),
        .s_axis_data    (s_axis_data),
        .m_axis_valid   (m_axis_valid),
        .m_axis_ready   (m_axis_ready),
        .m_axis_data    (m_axis_data),
        .running        (running),
        .underflow      (underflow),
        .insert_count   (insert_count),
        .underflow_count(underflow_count)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    int    in_idx = 0;
    bit    feed_en = 1'b0;
    bit    rdy_rand = 1'b0;
    bit    rdy_force = 1'b1;
    bit    idx_mode = 1'b0;
    int    beat_no = 0;
    beat_t model_last = '0;
    int    nins;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dbg(input int v);
        return DBG ? 64'(v) : 64'd0;
    endfunction

    // Insertion happens on output beat k when a0 + k*add crosses a multiple of 2^AW.
    function automatic bit carry_at(input longint a0, input longint add, input int k);
        longint modulus;
        modulus = longint'(1) << AW;
        return ((a0 + longint'(k) * add) / modulus) != ((a0 + longint'(k - 1) * add) / modulus);
    endfunction

    function automatic beat_t fill_of(input beat_t last, input logic [NCH-1:0] mask);
        beat_t b;
        b = last;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                for (int s = 0; s < SPC; s++) b[(c * SPC + s) * SW +: SW] = FILL;
            end
        end
        return b;
    endfunction

    function automatic beat_t gen_beat();
        beat_t b;
        if (idx_mode) begin
            for (int i = 0; i < NCH * SPC; i++) b[i * SW +: SW] = 16'(beat_no);
            beat_no++;
        end else begin
            for (int w = 0; w < DW / 32; w++) b[w * 32 +: 32] = $urandom;
        end
        return b;
    endfunction

    task automatic queue_bypass(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = gen_beat();
            in_q.push_back(b);
            exp_q.push_back(b);
            model_last = b;
        end
    endtask

    task automatic queue_run(input longint a0, input longint add, input int nout,
                             input logic [NCH-1:0] mask, output int n_ins);
        beat_t b;
        n_ins = 0;
        for (int k = 1; k <= nout; k++) begin
            if (carry_at(a0, add, k)) begin
                exp_q.push_back(fill_of(model_last, mask));
                n_ins++;
            end else begin
                b = gen_beat();
                in_q.push_back(b);
                exp_q.push_back(b);
                model_last = b;
            end
        end
    endtask

    task automatic start_run(input logic [AW-1:0] a0, input bit use_set, input logic [AW-1:0] add,
                             input int nout, input logic [NCH-1:0] mask, output int n_ins);
        @(negedge clk);
        fill_mask     = mask;
        accum_add_val = add;
        accum_set     = use_set;
        accum_set_val = a0;
        start         = 1'b1;
        queue_run(use_set ? longint'(a0) : 0, longint'(add), nout, mask, n_ins);
        feed_en = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        accum_set = 1'b0;
        check("start_running", 64'(running), 64'd1);
        check("start_underflow_clr", 64'(underflow), 64'd0);
        check("start_insert_count_clr", 64'(insert_count), 64'd0);
        check("start_underflow_count_clr", 64'(underflow_count), 64'd0);
    endtask

    task automatic stop_run();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        check("stop_running", 64'(running), 64'd0);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic flush_model();
        exp_q.delete();
        in_idx = in_q.size();
    endtask

    // Input feeder: holds each queued beat until the handshake completes.
    initial begin : feeder
        bit fire;
        s_axis_valid = 1'b0;
        s_axis_data  = '0;
        forever begin
            @(negedge clk);
            fire = s_axis_valid && s_axis_ready;
            @(posedge clk);
            #1;
            if (fire) in_idx++;
            if (feed_en && in_idx < in_q.size()) begin
                s_axis_valid = 1'b1;
                s_axis_data  = in_q[in_idx];
            end else begin
                s_axis_valid = 1'b0;
            end
        end
    end

    initial begin : ready_driver
        m_axis_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    initial begin : monitor
        beat_t e;
        int    nbeat;
        nbeat = 0;
        forever begin
            @(negedge clk);
            if (m_axis_valid && m_axis_ready) begin
                checks++;
                nbeat++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat #%0d: got %h, expected no beat", nbeat, m_axis_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_data !== e) begin
                        errors++;
                        $display("FAIL out_beat #%0d: got %h, expected %h", nbeat, m_axis_data, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; accum_set = 1'b0;
        accum_set_val = '0; accum_add_val = '0; fill_mask = '0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_axis_ready), 64'd0);
        check("rst_m_valid", 64'(m_axis_valid), 64'd0);
        check("rst_m_data_zero", 64'(m_axis_data == '0), 64'd1);
        check("rst_running", 64'(running), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);
        check("rst_insert_count", 64'(insert_count), 64'd0);
        check("rst_underflow_count", 64'(underflow_count), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("bypass_running", 64'(running), 64'd0);

        // Pre-start bypass: pure pass-through.
        queue_bypass(5);
        feed_en = 1'b1;
        wait_drain(200);

        // Every 4th beat inserted, repeat-last on all channels.
        idx_mode = 1'b1; beat_no = 1;
        start_run(8'h00, 1'b0, 8'h40, 12, 4'b0000, nins);
        wait_drain(500);
        check("t1_insert_count", 64'(insert_count), dbg(nins));
        stop_run();

        // Mixed fill mask with index-valued samples.
        beat_no = 1;
        start_run(8'h00, 1'b0, 8'h40, 12, 4'b0101, nins);
        wait_drain(500);
        check("t2_insert_count", 64'(insert_count), dbg(nins));
        stop_run();

        // Random back-pressure over 1000 output beats; accum_set mid-run must be ignored.
        idx_mode = 1'b0; rdy_rand = 1'b1;
        start_run(8'h00, 1'b0, 8'h10, 1000, 4'b0011, nins);
        repeat (100) @(negedge clk);
        accum_set = 1'b1; accum_set_val = 8'h77;
        @(negedge clk);
        accum_set = 1'b0;
        wait_drain(6000);
        rdy_rand = 1'b0;
        check("t3_insert_count", 64'(insert_count), dbg(nins));
        stop_run();

        // Zero increment, then a 5-cycle input starvation.
        start_run(8'h00, 1'b0, 8'h00, 30, 4'b0000, nins);
        repeat (8) @(negedge clk);
        feed_en = 1'b0;
        repeat (5) @(negedge clk);
        feed_en = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_underflow", 64'(underflow), 64'd1);
        check("t4_underflow_count", 64'(underflow_count), dbg(5));
        wait_drain(500);
        check("t4_insert_count", 64'(insert_count), 64'd0);
        stop_run();
        check("t4_underflow_sticky", 64'(underflow), 64'd1);

        // Stop while the output register is stalled; drain then plain bypass.
        start_run(8'h00, 1'b0, 8'h80, 6, 4'b0000, nins);
        wait_drain(500);
        @(negedge clk);
        rdy_force = 1'b0;
        queue_bypass(4);
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_drain_running", 64'(running), 64'd1);
        check("t5_drain_m_valid", 64'(m_axis_valid), 64'd1);
        check("t5_drain_s_ready", 64'(s_axis_ready), 64'd0);
        rdy_force = 1'b1;
        wait_drain(500);
        check("t5_after_drain_running", 64'(running), 64'd0);
        check("t5_insert_count", 64'(insert_count), dbg(nins));

        // Drop enable mid-run.
        rdy_rand = 1'b1;
        start_run(8'h00, 1'b0, 8'h40, 40, 4'b1111, nins);
        repeat (20) @(negedge clk);
        enable = 1'b0; feed_en = 1'b0;
        @(negedge clk);
        check("t6_en_m_valid", 64'(m_axis_valid), 64'd0);
        check("t6_en_s_ready", 64'(s_axis_ready), 64'd0);
        check("t6_en_running", 64'(running), 64'd0);
        flush_model();
        enable = 1'b1; rdy_rand = 1'b0; feed_en = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-run.
        rdy_rand = 1'b1;
        start_run(8'h00, 1'b0, 8'h40, 40, 4'b1111, nins);
        repeat (15) @(negedge clk);
        reset = 1'b1; feed_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("t7_rst_m_valid", 64'(m_axis_valid), 64'd0);
        check("t7_rst_s_ready", 64'(s_axis_ready), 64'd0);
        check("t7_rst_running", 64'(running), 64'd0);
        check("t7_rst_m_data_zero", 64'(m_axis_data == '0), 64'd1);
        check("t7_rst_underflow", 64'(underflow), 64'd0);
        check("t7_rst_insert_count", 64'(insert_count), 64'd0);
        flush_model();
        model_last = '0;
        rdy_rand = 1'b0; feed_en = 1'b1;
        repeat (3) @(negedge clk);

        // accum_set with start: immediate insertion repeats the cleared last-beat register.
        idx_mode = 1'b1; beat_no = 1;
        start_run(8'hC0, 1'b1, 8'h40, 5, 4'b0000, nins);
        wait_drain(500);
        check("t8_insert_count", 64'(insert_count), dbg(nins));
        stop_run();

        // Simultaneous start and stop: stop wins, no run, no insertion.
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("t9_start_stop_running", 64'(running), 64'd0);
        accum_add_val = 8'hFF;
        idx_mode = 1'b0;
        queue_bypass(6);
        wait_drain(200);
        check("t9_running", 64'(running), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
